// File: rtl/t01_instruction_fetch.sv
// t01_instruction_fetch: instruction fetch stage.
// Owns the PC, issues one word read at a time on the req/ack bus and holds
// the returned word with its PC in a one-entry register.
// Optional build macro T01_FETCH_MISALIGN_CHECK_EN: a misaligned redirect
// raises a sticky misalign_flt and parks the fetch in FAULT until an aligned
// redirect arrives. Without it, redirect targets are forced word aligned.
module t01_instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef T01_FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_flt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DRAIN
`ifdef T01_FETCH_MISALIGN_CHECK_EN
    ,
    S_FAULT
`endif
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] drain_addr, drain_addr_nx;
  logic        valid_nx;
  logic [31:0] instr_nx, instr_pc_nx;
  logic [31:0] tgt;
  logic        tgt_bad;
  logic        flt, flt_nx;

  // Redirect target as it will be loaded into the pc
`ifdef T01_FETCH_MISALIGN_CHECK_EN
  assign tgt     = redirect_pc;
  assign tgt_bad = redirect_pc[1:0] != 2'b00;
`else
  assign tgt     = redirect_pc & 32'hFFFF_FFFC;
  assign tgt_bad = 1'b0;
`endif

  // Bus outputs are decoded from state; DRAIN keeps presenting the address
  // of the request that was in flight when the redirect arrived.
  assign mem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign mem_addr = (state == S_DRAIN) ? drain_addr : pc;

`ifdef T01_FETCH_MISALIGN_CHECK_EN
  assign misalign_flt = flt;
`endif

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_BOOT;
    else       state <= state_nx;
  end

  // PC, drain address, output holding register and fault flag
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      flt         <= 1'b0;
    end else begin
      pc          <= pc_nx;
      drain_addr  <= drain_addr_nx;
      instr_valid <= valid_nx;
      instr       <= instr_nx;
      instr_pc    <= instr_pc_nx;
      flt         <= flt_nx;
    end
  end

  // Next-state and next-value logic; a redirect overrides every other event
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    valid_nx      = instr_valid;
    instr_nx      = instr;
    instr_pc_nx   = instr_pc;
    flt_nx        = flt;

    if (redirect_en) begin
      valid_nx = 1'b0;
      instr_nx = NOP_INSTR;
      if (tgt_bad) begin
        flt_nx = 1'b1;
      end else begin
        flt_nx = 1'b0;
        pc_nx  = tgt;
      end
      case (state)
        S_REQ: begin
          if (mem_ack) begin
            // Request finished this cycle; its data is dropped.
            state_nx = S_REQ;
`ifdef T01_FETCH_MISALIGN_CHECK_EN
            if (tgt_bad) state_nx = S_FAULT;
`endif
          end else begin
            state_nx      = S_DRAIN;
            drain_addr_nx = pc;
          end
        end
        S_DRAIN: begin
          // Newest redirect wins. If the old request completes in the same
          // cycle there is nothing left to drain, so leave immediately.
          state_nx = S_DRAIN;
          if (mem_ack) begin
            state_nx = S_REQ;
`ifdef T01_FETCH_MISALIGN_CHECK_EN
            if (flt_nx) state_nx = S_FAULT;
`endif
          end
        end
        default: begin
          state_nx = S_REQ;
`ifdef T01_FETCH_MISALIGN_CHECK_EN
          if (tgt_bad) state_nx = S_FAULT;
`endif
        end
      endcase
    end else begin
      case (state)
        S_BOOT: state_nx = S_REQ;
        S_REQ: begin
          if (mem_ack) begin
            instr_nx    = mem_rdata;
            instr_pc_nx = pc;
            pc_nx       = pc + 32'd4;
            valid_nx    = 1'b1;
            state_nx    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            valid_nx = 1'b0;
            instr_nx = NOP_INSTR;
            state_nx = S_REQ;
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            state_nx = S_REQ;
`ifdef T01_FETCH_MISALIGN_CHECK_EN
            if (flt) state_nx = S_FAULT;
`endif
          end
        end
        default: state_nx = state;
      endcase
    end
  end

endmodule
